// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared coin codes, FSM states and classification helper
package coin_acceptor_pkg;

    // Coin codes shared with the vending FSM
    localparam logic COIN_NICKEL = 1'b1;
    localparam logic COIN_DIME   = 1'b0;

    // Default parameter values
    localparam int DEF_DEBOUNCE   = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_NICKEL_MIN = 10;
    localparam int DEF_NICKEL_MAX = 20;
    localparam int DEF_DIME_MIN   = 30;
    localparam int DEF_DIME_MAX   = 50;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        CLASSIFY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_REJECT = 2'd0,
        CLS_NICKEL = 2'd1,
        CLS_DIME   = 2'd2
    } coin_class_t;

    // Map a measured width onto a coin class; a saturated counter is never a coin
    function automatic coin_class_t classify_width(
        input logic [31:0] w,
        input logic        saturated,
        input logic [31:0] nickel_min,
        input logic [31:0] nickel_max,
        input logic [31:0] dime_min,
        input logic [31:0] dime_max
    );
        coin_class_t cls;
        cls = CLS_REJECT;
        if (!saturated) begin
            if (w >= nickel_min && w <= nickel_max) begin
                cls = CLS_NICKEL;
            end else if (w >= dime_min && w <= dime_max) begin
                cls = CLS_DIME;
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - single-entry coin valid/ready handshake
interface coin_acceptor_if;
    import coin_acceptor_pkg::*;

    logic io_coin_valid;
    logic io_coin;
    logic io_coin_ready;

    modport master (
        output io_coin_valid,
        output io_coin,
        input  io_coin_ready
    );

    modport slave (
        input  io_coin_valid,
        input  io_coin,
        output io_coin_ready
    );

endinterface

// File: rtl/coin_acceptor_sensor_debounce.sv
// rtl/coin_acceptor_sensor_debounce.sv - two-flop synchronizer and stability-count debouncer
module sensor_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic d
);

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic            sync_1;
    logic            s;
    logic [DB_W-1:0] stable_cnt;

    // Bring the raw chute sensor into the clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_1 <= sensor;
            s      <= sync_1;
        end
    end

    // Flip d only after DEBOUNCE consecutive samples disagree with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d          <= 1'b0;
            stable_cnt <= '0;
        end else if (s != d) begin
            if (stable_cnt == DB_LAST) begin
                d          <= s;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin pulse measurement, classification and one-entry holding slot
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE   = DEF_DEBOUNCE,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NICKEL_MIN = DEF_NICKEL_MIN,
    parameter int NICKEL_MAX = DEF_NICKEL_MAX,
    parameter int DIME_MIN   = DEF_DIME_MIN,
    parameter int DIME_MAX   = DEF_DIME_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_sensor,
    coin_acceptor_if.master   coin_if,
    output logic              io_reject,
    output logic              io_overrun,
    output logic [CNT_W-1:0]  io_width
);

    localparam logic [CNT_W-1:0] W_SAT = {CNT_W{1'b1}};

    logic             d;
    state_t           state;
    logic [CNT_W-1:0] width;
    coin_class_t      cls;
    logic             drain;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .sensor (io_sensor),
        .d      (d)
    );

    // Classify the held measurement and detect a slot drain this cycle
    always_comb begin
        cls   = classify_width(32'(width), (width == W_SAT),
                               32'(NICKEL_MIN), 32'(NICKEL_MAX),
                               32'(DIME_MIN), 32'(DIME_MAX));
        drain = coin_if.io_coin_valid && coin_if.io_coin_ready;
    end

    // Measurement FSM with the holding slot and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                 <= IDLE;
            width                 <= '0;
            io_width              <= '0;
            io_reject             <= 1'b0;
            io_overrun            <= 1'b0;
            coin_if.io_coin_valid <= 1'b0;
            coin_if.io_coin       <= 1'b0;
        end else begin
            io_reject  <= 1'b0;
            io_overrun <= 1'b0;
            if (drain) begin
                coin_if.io_coin_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (d) begin
                        width <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (!d) begin
                        state <= CLASSIFY;
                    end else if (width != W_SAT) begin
                        width <= width + 1'b1;
                    end
                end
                CLASSIFY: begin
                    state    <= IDLE;
                    io_width <= width;
                    if (cls == CLS_REJECT) begin
                        io_reject <= 1'b1;
                    end else if (!coin_if.io_coin_valid || drain) begin
                        // A new coin overrides the drain so the slot stays full
                        coin_if.io_coin_valid <= 1'b1;
                        coin_if.io_coin       <= (cls == CLS_NICKEL) ? COIN_NICKEL : COIN_DIME;
                    end else begin
                        io_overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;

    logic       clk;
    logic       reset;
    logic       io_sensor;
    logic       io_reject;
    logic       io_overrun;
    logic [7:0] io_width;

    int errors;
    int checks;

    coin_acceptor_if cif();

    coin_acceptor dut (
        .clk        (clk),
        .reset      (reset),
        .io_sensor  (io_sensor),
        .coin_if    (cif.master),
        .io_reject  (io_reject),
        .io_overrun (io_overrun),
        .io_width   (io_width)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int n);
        io_sensor = 1'b1;
        repeat (n) tick();
        io_sensor = 1'b0;
    endtask

    task automatic idle_gap();
        repeat (12) tick();
    endtask

    int   bw [7];
    int   bk [7];
    logic seen;

    initial begin
        errors = 0;
        checks = 0;
        bw = '{10, 20, 9, 21, 30, 50, 51};
        bk = '{1, 1, 0, 0, 2, 2, 0};

        reset = 1'b0;
        io_sensor = 1'b0;
        cif.io_coin_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(cif.io_coin_valid), 0);
        check("rst_coin", 32'(cif.io_coin), 0);
        check("rst_reject", 32'(io_reject), 0);
        check("rst_overrun", 32'(io_overrun), 0);
        check("rst_width", 32'(io_width), 0);
        reset = 1'b1;
        repeat (3) tick();

        // Clean 15-cycle nickel, output 8 cycles after the raw fall
        pulse(15);
        repeat (7) tick();
        check("n15_early_valid", 32'(cif.io_coin_valid), 0);
        tick();
        check("n15_valid", 32'(cif.io_coin_valid), 1);
        check("n15_coin", 32'(cif.io_coin), 1);
        check("n15_width", 32'(io_width), 15);
        check("n15_reject", 32'(io_reject), 0);
        tick();
        check("n15_drained", 32'(cif.io_coin_valid), 0);
        idle_gap();

        // Clean 40-cycle dime
        pulse(40);
        repeat (8) tick();
        check("d40_valid", 32'(cif.io_coin_valid), 1);
        check("d40_coin", 32'(cif.io_coin), 0);
        check("d40_width", 32'(io_width), 40);
        tick();
        check("d40_drained", 32'(cif.io_coin_valid), 0);
        idle_gap();

        // Window boundaries: kind 1 = nickel, 2 = dime, 0 = reject
        for (int i = 0; i < 7; i++) begin
            pulse(bw[i]);
            repeat (8) tick();
            check($sformatf("bnd%0d_width", bw[i]), 32'(io_width), 32'(bw[i]));
            check($sformatf("bnd%0d_valid", bw[i]), 32'(cif.io_coin_valid), (bk[i] != 0) ? 1 : 0);
            check($sformatf("bnd%0d_reject", bw[i]), 32'(io_reject), (bk[i] == 0) ? 1 : 0);
            if (bk[i] != 0) begin
                check($sformatf("bnd%0d_coin", bw[i]), 32'(cif.io_coin), (bk[i] == 1) ? 1 : 0);
            end
            tick();
            check($sformatf("bnd%0d_pulse_end", bw[i]), 32'(io_reject | cif.io_coin_valid), 0);
            idle_gap();
        end

        // 25-cycle reject, then a 3-cycle glitch that must vanish
        pulse(25);
        repeat (8) tick();
        check("r25_reject", 32'(io_reject), 1);
        check("r25_overrun", 32'(io_overrun), 0);
        check("r25_width", 32'(io_width), 25);
        tick();
        check("r25_reject_end", 32'(io_reject), 0);
        idle_gap();
        pulse(3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | io_reject | cif.io_coin_valid | io_overrun;
        end
        check("glitch_no_output", 32'(seen), 0);
        check("glitch_width", 32'(io_width), 25);

        // Slot full and not draining: dime dropped with one overrun pulse
        cif.io_coin_ready = 1'b0;
        pulse(15);
        repeat (8) tick();
        check("ovr_first_valid", 32'(cif.io_coin_valid), 1);
        check("ovr_first_coin", 32'(cif.io_coin), 1);
        idle_gap();
        pulse(40);
        repeat (8) tick();
        check("ovr_pulse", 32'(io_overrun), 1);
        check("ovr_no_reject", 32'(io_reject), 0);
        check("ovr_held_valid", 32'(cif.io_coin_valid), 1);
        check("ovr_held_coin", 32'(cif.io_coin), 1);
        check("ovr_width", 32'(io_width), 40);
        tick();
        check("ovr_pulse_end", 32'(io_overrun), 0);
        check("ovr_still_coin", 32'(cif.io_coin), 1);
        cif.io_coin_ready = 1'b1;
        tick();
        check("ovr_handshake", 32'(cif.io_coin_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | cif.io_coin_valid | io_overrun;
        end
        check("ovr_single_handshake", 32'(seen), 0);

        // Drain coinciding with CLASSIFY: new coin loads, no overrun
        cif.io_coin_ready = 1'b0;
        pulse(15);
        repeat (8) tick();
        check("drn_first_valid", 32'(cif.io_coin_valid), 1);
        idle_gap();
        pulse(40);
        repeat (7) tick();
        cif.io_coin_ready = 1'b1;
        tick();
        check("drn_valid", 32'(cif.io_coin_valid), 1);
        check("drn_coin", 32'(cif.io_coin), 0);
        check("drn_no_overrun", 32'(io_overrun), 0);
        tick();
        check("drn_drained", 32'(cif.io_coin_valid), 0);
        idle_gap();

        // Reset mid-MEASURE at width 8, released with the sensor low
        io_sensor = 1'b1;
        repeat (14) tick();
        reset = 1'b0;
        io_sensor = 1'b0;
        tick();
        check("mrst_width", 32'(io_width), 0);
        check("mrst_valid", 32'(cif.io_coin_valid), 0);
        repeat (2) tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | cif.io_coin_valid | io_reject | io_overrun;
        end
        check("mrst_no_output", 32'(seen), 0);
        check("mrst_width_after", 32'(io_width), 0);
        pulse(15);
        repeat (8) tick();
        check("mrst_n15_valid", 32'(cif.io_coin_valid), 1);
        check("mrst_n15_coin", 32'(cif.io_coin), 1);
        check("mrst_n15_width", 32'(io_width), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
